// File: rtl/alu_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_branch_unit
//  Purpose  : 64-bit ALU with opcode decode, NZVC flag register and B.cond
//             resolution. Optional multiplier enabled by macro ALU_MUL_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_branch_unit (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [10:0] iOPCODE,
    input  logic [5:0]  iShamt,
    input  logic [4:0]  iALUop,
    input  logic [63:0] iA,
    input  logic [63:0] iB,
    input  logic [4:0]  iCondition,
    output logic [4:0]  oALUControl,
    output logic [63:0] oResult,
    output logic        oZero,
    output logic        oflagN,
    output logic        oflagZ,
    output logic        oflagV,
    output logic        oflagC,
    output logic        oTakeBranch
);

    localparam logic [4:0] c_op_and     = 5'd0;
    localparam logic [4:0] c_op_orr     = 5'd1;
    localparam logic [4:0] c_op_add     = 5'd2;
    localparam logic [4:0] c_op_eor     = 5'd3;
    localparam logic [4:0] c_op_lsl     = 5'd4;
    localparam logic [4:0] c_op_lsr     = 5'd5;
    localparam logic [4:0] c_op_sub     = 5'd6;
    localparam logic [4:0] c_op_passb   = 5'd7;
    localparam logic [4:0] c_op_mul     = 5'd8;
    localparam logic [4:0] c_op_invalid = 5'd31;

    logic [4:0]  w_ctrl;
    logic        w_set_flags;
    logic [64:0] w_sum;
    logic [63:0] w_diff;
    logic [63:0] w_result;
    logic        w_v;
    logic        w_c;
    logic        w_z;
    logic [3:0]  flags_d;   // {N, Z, V, C}
    logic [3:0]  flags_q;
    logic        w_n_q, w_z_q, w_v_q, w_c_q;
    logic        w_take;

    // Operation decode
    always_comb begin
        w_ctrl      = c_op_invalid;
        w_set_flags = 1'b0;
        case (iALUop)
            5'd0: w_ctrl = c_op_add;
            5'd1: w_ctrl = c_op_passb;
            5'd2: begin
                case (iOPCODE)
                    11'h458: w_ctrl = c_op_add;
                    11'h558: begin w_ctrl = c_op_add; w_set_flags = 1'b1; end
                    11'h658: w_ctrl = c_op_sub;
                    11'h758: begin w_ctrl = c_op_sub; w_set_flags = 1'b1; end
                    11'h450: w_ctrl = c_op_and;
                    11'h750: begin w_ctrl = c_op_and; w_set_flags = 1'b1; end
                    11'h550: w_ctrl = c_op_orr;
                    11'h650: w_ctrl = c_op_eor;
                    11'h69B: w_ctrl = c_op_lsl;
                    11'h69A: w_ctrl = c_op_lsr;
`ifdef ALU_MUL_EN
                    11'h4D8: w_ctrl = c_op_mul;
`endif
                    default: w_ctrl = c_op_invalid;
                endcase
            end
            5'd3: begin
                case (iOPCODE[10:1])
                    10'h244: w_ctrl = c_op_add;
                    10'h2C4: begin w_ctrl = c_op_add; w_set_flags = 1'b1; end
                    10'h344: w_ctrl = c_op_sub;
                    10'h3C4: begin w_ctrl = c_op_sub; w_set_flags = 1'b1; end
                    10'h248: w_ctrl = c_op_and;
                    10'h3C8: begin w_ctrl = c_op_and; w_set_flags = 1'b1; end
                    10'h2C8: w_ctrl = c_op_orr;
                    10'h348: w_ctrl = c_op_eor;
                    default: w_ctrl = c_op_invalid;
                endcase
            end
            default: w_ctrl = c_op_add;
        endcase
    end

    assign w_sum  = {1'b0, iA} + {1'b0, iB};
    assign w_diff = iA - iB;

    // Datapath; only add/sub produce carry and overflow
    always_comb begin
        w_result = 64'd0;
        w_v      = 1'b0;
        w_c      = 1'b0;
        case (w_ctrl)
            c_op_and:   w_result = iA & iB;
            c_op_orr:   w_result = iA | iB;
            c_op_eor:   w_result = iA ^ iB;
            c_op_lsl:   w_result = iA << iShamt;
            c_op_lsr:   w_result = iA >> iShamt;
            c_op_passb: w_result = iB;
            c_op_add: begin
                w_result = w_sum[63:0];
                w_c      = w_sum[64];
                w_v      = (iA[63] == iB[63]) && (w_sum[63] != iA[63]);
            end
            c_op_sub: begin
                w_result = w_diff;
                w_c      = (iA >= iB);
                w_v      = (iA[63] != iB[63]) && (w_diff[63] != iA[63]);
            end
`ifdef ALU_MUL_EN
            c_op_mul:   w_result = iA * iB;
`endif
            default:    w_result = 64'd0;
        endcase
    end

    assign w_z         = (w_result == 64'd0);
    assign oALUControl = w_ctrl;
    assign oResult     = w_result;
    assign oZero       = w_z;
    assign oflagN      = w_result[63];
    assign oflagZ      = w_z;
    assign oflagV      = w_v;
    assign oflagC      = w_c;

    always_comb begin
        flags_d = flags_q;
        if (w_set_flags) begin
            flags_d = {w_result[63], w_z, w_v, w_c};
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign {w_n_q, w_z_q, w_v_q, w_c_q} = flags_q;

    // Branch condition evaluated on the registered flags only
    always_comb begin
        w_take = 1'b0;
        case (iCondition)
            5'd0:  w_take = w_z_q;
            5'd1:  w_take = !w_z_q;
            5'd2:  w_take = w_c_q;
            5'd3:  w_take = !w_c_q;
            5'd4:  w_take = w_n_q;
            5'd5:  w_take = !w_n_q;
            5'd6:  w_take = w_v_q;
            5'd7:  w_take = !w_v_q;
            5'd8:  w_take = w_c_q && !w_z_q;
            5'd9:  w_take = !(w_c_q && !w_z_q);
            5'd10: w_take = (w_n_q == w_v_q);
            5'd11: w_take = (w_n_q != w_v_q);
            5'd12: w_take = !w_z_q && (w_n_q == w_v_q);
            5'd13: w_take = !(!w_z_q && (w_n_q == w_v_q));
            5'd14: w_take = 1'b1;
            5'd15: w_take = 1'b1;
            default: w_take = 1'b0;
        endcase
    end

    assign oTakeBranch = w_take;

endmodule
`default_nettype wire

// File: tb/tb_alu_branch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_branch_unit
//  Purpose  : Randomized and directed self-checking bench for alu_branch_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_branch_unit;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [10:0] iOPCODE;
    logic [5:0]  iShamt;
    logic [4:0]  iALUop;
    logic [63:0] iA;
    logic [63:0] iB;
    logic [4:0]  iCondition;
    logic [4:0]  oALUControl;
    logic [63:0] oResult;
    logic        oZero, oflagN, oflagZ, oflagV, oflagC, oTakeBranch;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] m_flags;   // model flag register {N,Z,V,C}
    logic       p_setf;
    logic [3:0] p_flags;

    alu_branch_unit dut (
        .iCLK(iCLK), .iRST(iRST), .iOPCODE(iOPCODE), .iShamt(iShamt),
        .iALUop(iALUop), .iA(iA), .iB(iB), .iCondition(iCondition),
        .oALUControl(oALUControl), .oResult(oResult), .oZero(oZero),
        .oflagN(oflagN), .oflagZ(oflagZ), .oflagV(oflagV), .oflagC(oflagC),
        .oTakeBranch(oTakeBranch)
    );

    always #5 iCLK = ~iCLK;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: op name from the instruction tables, then value from arithmetic
    function automatic void model_alu(input logic [4:0] aluop, input logic [10:0] opc,
                                      input logic [5:0] sh, input logic [63:0] a,
                                      input logic [63:0] b, output logic [4:0] code,
                                      output logic setf, output logic [63:0] r,
                                      output logic [3:0] f);
        string op;
        logic  v, c;
        op   = "ADD";
        setf = 1'b0;
        if (aluop == 5'd1) op = "PASSB";
        else if (aluop == 5'd2) begin
            case (opc)
                11'h458: op = "ADD";
                11'h558: begin op = "ADD"; setf = 1'b1; end
                11'h658: op = "SUB";
                11'h758: begin op = "SUB"; setf = 1'b1; end
                11'h450: op = "AND";
                11'h750: begin op = "AND"; setf = 1'b1; end
                11'h550: op = "ORR";
                11'h650: op = "EOR";
                11'h69B: op = "LSL";
                11'h69A: op = "LSR";
`ifdef ALU_MUL_EN
                11'h4D8: op = "MUL";
`endif
                default: op = "INVALID";
            endcase
        end else if (aluop == 5'd3) begin
            case (opc[10:1])
                10'h244: op = "ADD";
                10'h2C4: begin op = "ADD"; setf = 1'b1; end
                10'h344: op = "SUB";
                10'h3C4: begin op = "SUB"; setf = 1'b1; end
                10'h248: op = "AND";
                10'h3C8: begin op = "AND"; setf = 1'b1; end
                10'h2C8: op = "ORR";
                10'h348: op = "EOR";
                default: op = "INVALID";
            endcase
        end
        v = 1'b0;
        c = 1'b0;
        r = 64'd0;
        code = 5'd31;
        case (op)
            "AND":   begin code = 5'd0; r = a & b; end
            "ORR":   begin code = 5'd1; r = a | b; end
            "EOR":   begin code = 5'd3; r = a ^ b; end
            "LSL":   begin code = 5'd4; r = a; for (int i = 0; i < sh; i++) r = r * 2; end
            "LSR":   begin code = 5'd5; r = a; for (int i = 0; i < sh; i++) r = r / 2; end
            "PASSB": begin code = 5'd7; r = b; end
            "MUL":   begin code = 5'd8; r = a * b; end
            "ADD": begin
                code = 5'd2;
                r = a + b;
                c = (r < a);
                v = ($signed(a) >= 0 && $signed(b) >= 0 && $signed(r) < 0) ||
                    ($signed(a) < 0 && $signed(b) < 0 && $signed(r) >= 0);
            end
            "SUB": begin
                code = 5'd6;
                r = a - b;
                c = (a >= b);
                v = ($signed(a) >= 0 && $signed(b) < 0 && $signed(r) < 0) ||
                    ($signed(a) < 0 && $signed(b) >= 0 && $signed(r) >= 0);
            end
            default: begin code = 5'd31; r = 64'd0; end
        endcase
        f = {r[63], (r == 64'd0), v, c};
    endfunction

    function automatic logic model_br(input logic [4:0] cond, input logic [3:0] fl);
        logic n, z, v, c;
        {n, z, v, c} = fl;
        case (cond)
            0: return z;          1: return !z;
            2: return c;          3: return !c;
            4: return n;          5: return !n;
            6: return v;          7: return !v;
            8: return c && !z;    9: return !(c && !z);
            10: return n == v;    11: return n != v;
            12: return !z && (n == v);
            13: return !(!z && (n == v));
            14, 15: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Drive inputs mid-cycle and compare all combinational outputs to the model
    task automatic apply(input logic [4:0] aluop, input logic [10:0] opc, input logic [5:0] sh,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] cond);
        logic [4:0]  code;
        logic [63:0] r;
        iALUop = aluop; iOPCODE = opc; iShamt = sh; iA = a; iB = b; iCondition = cond;
        model_alu(aluop, opc, sh, a, b, code, p_setf, r, p_flags);
        #1;
        check_val("ctrl",   {59'd0, oALUControl}, {59'd0, code});
        check_val("result", oResult, r);
        check_val("zero",   {63'd0, oZero}, {63'd0, (r == 64'd0)});
        check_val("nzvc",   {60'd0, oflagN, oflagZ, oflagV, oflagC}, {60'd0, p_flags});
        check_val("branch", {63'd0, oTakeBranch}, {63'd0, model_br(cond, m_flags)});
    endtask

    task automatic clk_edge();
        @(posedge iCLK);
        if (!iRST && p_setf) m_flags = p_flags;
        @(negedge iCLK);
        #2;
    endtask

    task automatic check_branch(input string tag, input logic [4:0] cond, input logic exp);
        iCondition = cond;
        #1;
        check_val(tag, {63'd0, oTakeBranch}, {63'd0, exp});
        check_val({tag, "_model"}, {63'd0, oTakeBranch}, {63'd0, model_br(cond, m_flags)});
    endtask

    logic [10:0] r_ops [11] = '{11'h458, 11'h558, 11'h658, 11'h758, 11'h450, 11'h750,
                                11'h550, 11'h650, 11'h69B, 11'h69A, 11'h4D8};
    logic [9:0]  i_ops [8]  = '{10'h244, 10'h2C4, 10'h344, 10'h3C4, 10'h248, 10'h3C8,
                                10'h2C8, 10'h348};

    initial begin
        logic [4:0]  aluop;
        logic [10:0] opc;
        logic [63:0] a, b;
        int          sel;
        m_flags = 4'b0000;
        iRST = 1'b1; iOPCODE = '0; iShamt = '0; iALUop = '0; iA = '0; iB = '0; iCondition = '0;
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        #2;
        check_branch("rst_eq", 5'd0, 1'b0);
        check_branch("rst_ne", 5'd1, 1'b1);
        check_branch("rst_al", 5'd14, 1'b1);
        iRST = 1'b0;

        // ADD without flag update
        apply(5'd2, 11'h458, 6'd0, 64'd5, 64'd7, 5'd0);
        check_val("add_res", oResult, 64'd12);
        check_val("add_ctrl", {59'd0, oALUControl}, 64'd2);
        check_val("add_flags", {60'd0, oflagN, oflagZ, oflagV, oflagC}, 64'd0);
        clk_edge();
        check_branch("add_keep", 5'd1, 1'b1);

        // SUBS equal operands; same-cycle branch still sees old flags
        apply(5'd2, 11'h758, 6'd0, 64'd3, 64'd3, 5'd0);
        check_val("subs_nzvc", {60'd0, oflagN, oflagZ, oflagV, oflagC}, 64'b0101);
        check_val("subs_same_cyc", {63'd0, oTakeBranch}, 64'd0);
        clk_edge();
        check_branch("subs_eq", 5'd0, 1'b1);
        check_branch("subs_ne", 5'd1, 1'b0);

        // ADDS signed overflow
        apply(5'd2, 11'h558, 6'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd6);
        check_val("adds_nzvc", {60'd0, oflagN, oflagZ, oflagV, oflagC}, 64'b1010);
        clk_edge();
        check_branch("adds_vs", 5'd6, 1'b1);
        check_branch("adds_lt", 5'd11, 1'b0);

        // Shift boundaries
        apply(5'd2, 11'h69B, 6'd63, 64'd1, 64'd0, 5'd14);
        check_val("lsl63", oResult, 64'h8000_0000_0000_0000);
        apply(5'd2, 11'h69A, 6'd1, 64'd1, 64'd0, 5'd14);
        check_val("lsr1", oResult, 64'd0);
        apply(5'd2, 11'h69A, 6'd0, 64'hDEAD_BEEF_0000_0001, 64'd0, 5'd14);
        check_val("lsr0", oResult, 64'hDEAD_BEEF_0000_0001);
        clk_edge();

        // CBZ zero test and optional multiplier
        apply(5'd1, 11'h000, 6'd0, 64'd9, 64'd0, 5'd14);
        check_val("cbz_zero", {63'd0, oZero}, 64'd1);
        apply(5'd2, 11'h4D8, 6'd0, 64'd6, 64'd7, 5'd14);
`ifdef ALU_MUL_EN
        check_val("mul", oResult, 64'd42);
`else
        check_val("mul_off", oResult, 64'd0);
        check_val("mul_off_ctrl", {59'd0, oALUControl}, 64'd31);
`endif
        clk_edge();

        // Asynchronous reset between edges after Z was set
        apply(5'd2, 11'h758, 6'd0, 64'd3, 64'd3, 5'd0);
        clk_edge();
        check_branch("pre_rst_eq", 5'd0, 1'b1);
        iRST = 1'b1;
        m_flags = 4'b0000;
        check_branch("async_rst_eq", 5'd0, 1'b0);
        check_branch("async_rst_al", 5'd14, 1'b1);
        apply(5'd2, 11'h758, 6'd0, 64'd3, 64'd3, 5'd0);
        clk_edge();
        check_branch("rst_hold_eq", 5'd0, 1'b0);
        iRST = 1'b0;
        apply(5'd2, 11'h758, 6'd0, 64'd3, 64'd3, 5'd0);
        clk_edge();
        check_branch("rst_resume_eq", 5'd0, 1'b1);

        // Randomized traffic
        for (int it = 0; it < 600; it++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      aluop = 5'd0;
            else if (sel == 1) aluop = 5'd1;
            else if (sel <= 5) aluop = 5'd2;
            else if (sel <= 8) aluop = 5'd3;
            else               aluop = 5'($urandom_range(4, 31));
            if (aluop == 5'd3)
                opc = ($urandom_range(0, 7) == 0) ? 11'($urandom) : {i_ops[$urandom_range(0, 7)], 1'($urandom)};
            else
                opc = ($urandom_range(0, 7) == 0) ? 11'($urandom) : r_ops[$urandom_range(0, 10)];
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: b = a;
                1: a = {1'b0, 63'($signed(-1))};
                2: b = {32'd0, $urandom};
                3: a = {1'b1, a[62:0]};
                default: ;
            endcase
            apply(aluop, opc, 6'($urandom), a, b, 5'($urandom));
            clk_edge();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_branch_unit.md
ALU_BRANCH_UNIT -- requirements
Module: alu_branch_unit

Interface
REQ-001 SHALL use a single clock and an asynchronous, active-high reset:
- iCLK  in  1  rising-edge clock.
- iRST  in  1  async active-high reset.
REQ-002 Data and control ports:
- iOPCODE  in  11  instruction bits [31:21].
- iShamt  in  6  shift amount, instruction bits [15:10].
- iALUop  in  5  op class from main control.
- iA  in  64  operand A.
- iB  in  64  operand B.
- iCondition  in  5  B.cond code, instruction bits [4:0].
- oALUControl  out  5  decoded ALU operation.
- oResult  out  64  ALU result.
- oZero  out  1  oResult==0.
- oflagN, oflagZ, oflagV, oflagC  out  1 each  combinational flags of current op.
- oTakeBranch  out  1  condition met on registered flags.

Function
REQ-003 oALUControl codes (comb.): AND=0, ORR=1, ADD=2, EOR=3, LSL=4, LSR=5, SUB=6, PASSB=7, MUL=8, INVALID=31.
REQ-004 iALUop decode:
- 0: ADD (load/store address).
- 1: PASSB (CBZ zero test).
- 2: R-type from iOPCODE.
- 3: I-type from iOPCODE[10:1].
- 4-31: ADD.
REQ-005 R-type iOPCODE:
- 0x458 ADD, 0x558 ADDS.
- 0x658 SUB, 0x758 SUBS.
- 0x450 AND, 0x750 ANDS.
- 0x550 ORR, 0x650 EOR.
- 0x69B LSL, 0x69A LSR.
- else INVALID.
REQ-006 I-type iOPCODE[10:1]:
- 0x244 ADDI, 0x2C4 ADDIS.
- 0x344 SUBI, 0x3C4 SUBIS.
- 0x248 ANDI, 0x3C8 ANDIS.
- 0x2C8 ORRI, 0x348 EORI.
- else INVALID.
REQ-007 Results, mod 2^64:
- ADD A+B; SUB A-B; bitwise AND/ORR/EOR.
- LSL A<<iShamt; LSR A>>iShamt, logical, zero fill; iShamt 0 returns A.
- PASSB B; MUL low 64 bits of A*B; INVALID 0.
REQ-008 Flags:
- N=oResult[63]; Z=oZero.
- ADD: C=carry out of bit 63; V=(A[63]==B[63])&&(R[63]!=A[63]).
- SUB: C=1 when A>=B unsigned, no borrow; V=(A[63]!=B[63])&&(R[63]!=A[63]).
- All other ops: V=C=0.
REQ-009 Flag-setting ops (ADDS, SUBS, ANDS, ADDIS, SUBIS, ANDIS) SHALL latch {N,Z,V,C} into an internal flag register on the next rising iCLK; all other ops leave it unchanged.
REQ-010 oTakeBranch (comb.) from registered flags, by iCondition:
- 0 EQ Z; 1 NE !Z.
- 2 HS C; 3 LO !C.
- 4 MI N; 5 PL !N.
- 6 VS V; 7 VC !V.
- 8 HI C&!Z; 9 LS !(C&!Z).
- 10 GE N==V; 11 LT N!=V.
- 12 GT !Z&(N==V); 13 LE !(GT).
- 14, 15 AL 1; 16-31 0.
REQ-011 A flag-setting op followed by B.cond SHALL see the new flags from the cycle after the latching edge; a B.cond in the same cycle uses the old flags.
REQ-012 All outputs except oTakeBranch SHALL be purely combinational in the current inputs; zero cycle latency.

Reset
REQ-013 iRST high SHALL clear the flag register to 0000 asynchronously; while held, oTakeBranch reflects cleared flags (EQ=0, NE=1, AL=1).
REQ-014 Reset released mid-sequence SHALL resume latching at the first rising iCLK with iRST low.

Configuration
REQ-015 Macro ALU_MUL_EN:
- Defined: R-type 0x4D8 decodes to MUL (code 8).
- Undefined: 0x4D8 decodes to INVALID, and code 8 yields result 0 with all-zero flags.

Verification
REQ-016 ALUop=2, opcode 0x458, A=5, B=7 -> oResult=12, oALUControl=2, flags 0000, flag register unchanged.
REQ-017 SUBS (0x758), A=3, B=3, clock edge -> Z=1, C=1, N=0, V=0; then cond 0 -> oTakeBranch=1, cond 1 -> 0.
REQ-018 ADDS, A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> N=1, V=1, C=0; after edge cond 6 (VS) -> 1, cond 11 (LT) -> 0.
REQ-019 LSL (0x69B), A=1, iShamt=63 -> oResult=0x8000_0000_0000_0000; LSR, same A, iShamt=1 -> 0.
REQ-020 After SUBS sets Z=1, assert iRST between edges -> flags clear immediately, cond 0 -> 0, cond 14 -> 1.
REQ-021 ALUop=1, B=0 -> oZero=1; ALUop=2, opcode 0x4D8, A=6, B=7 -> 42 with ALU_MUL_EN, 0 without.
